// File: rtl/sram_frame_writer.sv
// sram_frame_writer
// Front end of the SRAM interface: a small pixel FIFO feeding sequential frame
// writes, and a display read port sharing the same SRAM access slot. Every
// write occupies two cycles (WRITE strobe, then WHOLD while the interface pulses
// WE_N). Every read occupies one cycle (READ), and its data comes back on
// oReadData two cycles later.

module sram_frame_writer #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int FRAME_WORDS = 153600,
  parameter int FIFO_DEPTH  = 4      // power of 2, at least 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFrameStart,
  input  logic              iPixValid,
  input  logic [DATA_W-1:0] iPixData,
  input  logic              iReadReq,
  input  logic [ADDR_W-1:0] iReadAddr,
  input  logic [DATA_W-1:0] iMemReadData,
  output logic              oCtrlWrite,
  output logic [ADDR_W-1:0] oWriteAddr,
  output logic [DATA_W-1:0] oWriteData,
  output logic [ADDR_W-1:0] oReadAddr,
  output logic              oReadAck,
  output logic [DATA_W-1:0] oReadData,
  output logic              oReadValid,
  output logic              oOverflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_WHOLD = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  fifo_wr_q, fifo_rd_q;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              skip_inc_q, skip_inc_d;

  logic [ADDR_W-1:0] write_addr_q;
  logic [DATA_W-1:0] write_data_q;
  logic [ADDR_W-1:0] read_addr_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] read_data_q;
  logic              read_valid_q;
  logic              overflow_q;

  logic fifo_full, fifo_empty;
  logic push, pop, drop;
  logic enter_read;
  logic [ADDR_W-1:0] wptr_inc;

  // Full/empty come from the registered count, so a same-cycle pop does not
  // make room for a same-cycle pixel.
  assign fifo_full  = (fifo_cnt_q == FULL_CNT);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = iPixValid && !fifo_full;
  assign drop       = iPixValid &&  fifo_full;

  // Dispatch: a pending read wins unless the FIFO is full or a read just ran.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (state_q == S_WRITE) begin
      state_d = S_WHOLD;
    end else if (iReadReq && !fifo_full && (state_q != S_READ)) begin
      state_d = S_READ;
    end else if (!fifo_empty) begin
      state_d = S_WRITE;
      pop     = 1'b1;
    end else begin
      state_d = S_IDLE;
    end
  end

  assign enter_read = (state_d == S_READ);

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Frame write pointer. It holds the address of the next write and advances
  // on exit from WHOLD. A frame start during the WRITE cycle has already
  // rewound the pointer to 0, so the WHOLD exit of that same write must not
  // advance it again. The following write then lands at address 0.
  assign wptr_inc = (wptr_q == LAST_ADDR) ? '0 : wptr_q + ADDR_W'(1);

  always_comb begin
    wptr_d = wptr_q;
    if ((state_q == S_WHOLD) && !skip_inc_q) begin
      wptr_d = wptr_inc;
    end
    if (iFrameStart) begin
      wptr_d = '0;
    end
  end

  always_comb begin
    skip_inc_d = (state_q == S_WRITE) && iFrameStart;
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // FSM state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pixel storage. Only the pointers are reset; stale words are never read.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_mem[fifo_wr_q] <= iPixData;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        fifo_wr_q <= fifo_wr_q + PTR_W'(1);
      end
      if (pop) begin
        fifo_rd_q <= fifo_rd_q + PTR_W'(1);
      end
    end
  end

  // Frame write pointer and its skip-once flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wptr_q     <= '0;
      skip_inc_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      skip_inc_q <= skip_inc_d;
    end
  end

  // On WRITE entry, latch the FIFO head and the address it goes to. The address
  // is taken from the next-state pointer, so a back-to-back dispatch from WHOLD
  // already sees the advanced (or frame-start rewound) value.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      write_addr_q <= '0;
      write_data_q <= '0;
    end else if (pop) begin
      write_addr_q <= wptr_d;
      write_data_q <= fifo_mem[fifo_rd_q];
    end
  end

  // On READ entry, latch the requested address for the interface.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      read_addr_q <= '0;
    end else if (enter_read) begin
      read_addr_q <= iReadAddr;
    end
  end

  // Read return pipe: the interface presents data the cycle after READ, and
  // that data is registered here to appear one cycle later with oReadValid.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_pend_q    <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      rd_pend_q    <= (state_q == S_READ);
      read_valid_q <= rd_pend_q;
      if (rd_pend_q) begin
        read_data_q <= iMemReadData;
      end
    end
  end

  // Sticky overflow flag. A drop in the same cycle as a frame start still
  // sets it, so a lost pixel is never silently hidden.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (iFrameStart) begin
      overflow_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all come straight from registers. The strobes are decoded from the
  // state register, so the asynchronous reset clears them at once.
  // ---------------------------------------------------------------------------
  assign oCtrlWrite = (state_q == S_WRITE);
  assign oReadAck   = (state_q == S_READ);
  assign oWriteAddr = write_addr_q;
  assign oWriteData = write_data_q;
  assign oReadAddr  = read_addr_q;
  assign oReadData  = read_data_q;
  assign oReadValid = read_valid_q;
  assign oOverflow  = overflow_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// tb_sram_frame_writer
// Directed scenarios followed by a randomized run. A transaction-level model
// (pixel queue, next-address counter, read slot bookkeeping) predicts every
// output each cycle. The frame is shortened so the pointer wrap is reachable.

module tb_sram_frame_writer;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int FW = 40;
  localparam int FD = 4;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iFrameStart = 1'b0;
  logic          iPixValid = 1'b0;
  logic [DW-1:0] iPixData = '0;
  logic          iReadReq = 1'b0;
  logic [AW-1:0] iReadAddr = '0;
  logic [DW-1:0] iMemReadData = '0;
  logic          oCtrlWrite;
  logic [AW-1:0] oWriteAddr;
  logic [DW-1:0] oWriteData;
  logic [AW-1:0] oReadAddr;
  logic          oReadAck;
  logic [DW-1:0] oReadData;
  logic          oReadValid;
  logic          oOverflow;

  sram_frame_writer #(
    .ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW), .FIFO_DEPTH(FD)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iFrameStart(iFrameStart),
    .iPixValid(iPixValid), .iPixData(iPixData),
    .iReadReq(iReadReq), .iReadAddr(iReadAddr), .iMemReadData(iMemReadData),
    .oCtrlWrite(oCtrlWrite), .oWriteAddr(oWriteAddr), .oWriteData(oWriteData),
    .oReadAddr(oReadAddr), .oReadAck(oReadAck), .oReadData(oReadData),
    .oReadValid(oReadValid), .oOverflow(oOverflow)
  );

  initial forever #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int rd_pct = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic tick();
    @(negedge iCLK);
    iMemReadData = DW'($urandom);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];
  int            m_phase;   // 0: free slot, 1: write strobe cycle, 2: write hold cycle
  bit            m_rd;      // current cycle is a read slot
  bit            m_pend;    // read data due from the interface this cycle
  int            m_ptr;     // address the next dispatched write will use
  logic          e_ctrl, e_ack, e_rvalid, e_ovf;
  logic [AW-1:0] e_waddr, e_raddr;
  logic [DW-1:0] e_wdata, e_rdata;

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_rd = 1'b0; m_pend = 1'b0; m_ptr = 0;
    e_ctrl = 1'b0; e_ack = 1'b0; e_rvalid = 1'b0; e_ovf = 1'b0;
    e_waddr = '0; e_raddr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  task automatic model_step();
    bit full, empty, was_rd;
    full   = (mq.size() == FD);
    empty  = (mq.size() == 0);
    was_rd = m_rd;
    e_rvalid = m_pend;
    if (m_pend) e_rdata = iMemReadData;
    m_pend = was_rd;
    if (iFrameStart) m_ptr = 0;
    m_rd = 1'b0;
    if (m_phase == 1) begin
      m_phase = 2;
    end else if (iReadReq && !full && !was_rd) begin
      m_rd = 1'b1;
      m_phase = 0;
      e_raddr = iReadAddr;
    end else if (!empty) begin
      e_wdata = mq.pop_front();
      e_waddr = AW'(m_ptr);
      m_ptr = (m_ptr + 1) % FW;
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
    if (iPixValid && full) begin
      e_ovf = 1'b1;
    end else begin
      if (iPixValid) mq.push_back(iPixData);
      if (iFrameStart) e_ovf = 1'b0;
    end
    e_ctrl = (m_phase == 1);
    e_ack  = m_rd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge iCLK or negedge iRST_N);
      if (!iRST_N) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge iCLK);
    if (chk_en && iRST_N) begin
      chk("ctrl_write", 32'(oCtrlWrite), 32'(e_ctrl));
      chk("write_addr", 32'(oWriteAddr), 32'(e_waddr));
      chk("write_data", 32'(oWriteData), 32'(e_wdata));
      chk("read_addr",  32'(oReadAddr),  32'(e_raddr));
      chk("read_ack",   32'(oReadAck),   32'(e_ack));
      chk("read_data",  32'(oReadData),  32'(e_rdata));
      chk("read_valid", 32'(oReadValid), 32'(e_rvalid));
      chk("overflow",   32'(oOverflow),  32'(e_ovf));
    end
  end

  // ---------------- write monitor and read requester ----------------
  logic [AW+DW-1:0] obs[$];

  initial forever begin
    @(negedge iCLK);
    if (iRST_N && oCtrlWrite) begin
      obs.push_back({oWriteAddr, oWriteData});
      $display("write addr=%0d data=%h", oWriteAddr, oWriteData);
    end
    if (iRST_N && oReadValid) $display("read  data=%h", oReadData);
  end

  initial forever begin
    @(negedge iCLK);
    if (oReadAck) iReadReq = 1'b0;
    if (rd_pct > 0 && !iReadReq && ($urandom_range(99) < 32'(rd_pct))) begin
      iReadReq  = 1'b1;
      iReadAddr = AW'($urandom);
    end
  end

  task automatic chk_w(input string nm, input int idx, input int a, input int d);
    logic [AW+DW-1:0] e;
    if (idx >= obs.size()) begin
      total++;
      bad++;
      $display("FAIL %s: write #%0d missing (%0d seen), required addr=%0d data=%h", nm, idx, obs.size(), a, d);
    end else begin
      e = obs[idx];
      chk({nm, "_addr"}, 32'(e[AW+DW-1:DW]), a);
      chk({nm, "_data"}, 32'(e[DW-1:0]), d);
    end
  endtask

  task automatic send_pix(input logic [DW-1:0] d);
    iPixValid = 1'b1;
    iPixData  = d;
    tick();
    iPixValid = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    repeat (3) tick();
    iRST_N = 1'b1;
    tick();
    chk("rst_ctrl",   32'(oCtrlWrite), 0);
    chk("rst_waddr",  32'(oWriteAddr), 0);
    chk("rst_wdata",  32'(oWriteData), 0);
    chk("rst_ack",    32'(oReadAck),   0);
    chk("rst_rvalid", 32'(oReadValid), 0);
    chk("rst_ovf",    32'(oOverflow),  0);
    chk_en = 1'b1;

    // Reset in the middle of a write strobe.
    iPixValid = 1'b1; iPixData = 16'h0A0A; tick();
    iPixData = 16'h0B0B; tick();
    iPixValid = 1'b0;
    chk("t1_write_seen", 32'(oCtrlWrite), 1);
    #2 iRST_N = 1'b0;
    #1;
    chk("t1_ctrl_async", 32'(oCtrlWrite), 0);
    chk("t1_waddr_async", 32'(oWriteAddr), 0);
    tick();
    iRST_N = 1'b1;
    repeat (4) begin
      tick();
      chk("t1_fifo_empty", 32'(oCtrlWrite), 0);
    end

    // Three pixels, one every two cycles.
    obs.delete();
    send_pix(16'h1111); send_pix(16'h2222); send_pix(16'h3333);
    repeat (4) tick();
    chk("t2_count", obs.size(), 3);
    chk_w("t2_w0", 0, 0, 16'h1111);
    chk_w("t2_w1", 1, 1, 16'h2222);
    chk_w("t2_w2", 2, 2, 16'h3333);

    // Pointer wrap at the last frame word.
    obs.delete();
    for (int i = 0; i < 36; i++) send_pix(DW'(32'h1000 + i));
    send_pix(16'hABCD);
    send_pix(16'h0001);
    repeat (4) tick();
    chk("t3_count", obs.size(), 38);
    chk_w("t3_first", 0, 3, 16'h1000);
    chk_w("t3_last", 36, FW - 1, 16'hABCD);
    chk_w("t3_wrap", 37, 0, 16'h0001);

    // Read takes the slot ahead of queued pixels; data returns two cycles later.
    obs.delete();
    iPixValid = 1'b1; iPixData = 16'h4444;
    iReadReq = 1'b1; iReadAddr = 18'h000FF;
    tick();
    chk("t4_ack", 32'(oReadAck), 1);
    chk("t4_raddr", 32'(oReadAddr), 32'h000FF);
    chk("t4_ctrl_in_read", 32'(oCtrlWrite), 0);
    iReadReq = 1'b0; iPixData = 16'h5555;
    tick();
    iPixValid = 1'b0;
    chk("t4_ack_pulse", 32'(oReadAck), 0);
    chk("t4_rvalid_early", 32'(oReadValid), 0);
    chk("t4_write_after", 32'(oCtrlWrite), 1);
    iMemReadData = 16'hBEEF;
    tick();
    chk("t4_rvalid", 32'(oReadValid), 1);
    chk("t4_rdata", 32'(oReadData), 16'hBEEF);
    tick();
    chk("t4_rvalid_pulse", 32'(oReadValid), 0);
    repeat (6) tick();
    chk_w("t4_w0", 0, 1, 16'h4444);
    chk_w("t4_w1", 1, 2, 16'h5555);

    // Burst of pixels under continuous read pressure overflows the FIFO.
    rd_pct = 100;
    tick();
    iPixValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      iPixData = DW'(32'h6000 + i);
      tick();
    end
    iPixValid = 1'b0;
    rd_pct = 0;
    repeat (14) tick();
    chk("t5_ovf", 32'(oOverflow), 1);
    repeat (3) tick();
    chk("t5_ovf_sticky", 32'(oOverflow), 1);
    iFrameStart = 1'b1; tick(); iFrameStart = 1'b0;
    chk("t5_ovf_clr", 32'(oOverflow), 0);
    obs.delete();
    send_pix(16'h7777);
    repeat (4) tick();
    chk_w("t5_restart", 0, 0, 16'h7777);

    // Frame start coincident with the hold cycle of the write at address 5.
    for (int i = 1; i <= 4; i++) send_pix(DW'(32'h8000 + i));
    repeat (3) tick();
    obs.delete();
    iPixValid = 1'b1; iPixData = 16'h8005; tick();
    iPixData = 16'h8006; tick();
    iPixValid = 1'b0;
    n = 0;
    while (!(oCtrlWrite && oWriteAddr == 18'd5) && n < 10) begin
      tick();
      n++;
    end
    if (n >= 10) timeout("t6_wait_addr5");
    tick();
    chk("t6_whold_ctrl", 32'(oCtrlWrite), 0);
    chk("t6_whold_addr", 32'(oWriteAddr), 5);
    iFrameStart = 1'b1; tick(); iFrameStart = 1'b0;
    chk("t6_next_ctrl", 32'(oCtrlWrite), 1);
    chk("t6_next_addr", 32'(oWriteAddr), 0);
    repeat (3) tick();
    send_pix(16'h8007);
    repeat (4) tick();
    chk_w("t6_w5", 0, 5, 16'h8005);
    chk_w("t6_w0", 1, 0, 16'h8006);
    chk_w("t6_w1", 2, 1, 16'h8007);

    // Randomized traffic.
    rd_pct = 25;
    for (int c = 0; c < 4000; c++) begin
      iPixValid   = ($urandom_range(99) < 45);
      iPixData    = DW'($urandom);
      iFrameStart = ($urandom_range(149) == 0);
      tick();
    end
    iPixValid = 1'b0;
    iFrameStart = 1'b0;
    rd_pct = 0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
